amo_agent_sequencer: RTL

Per-agent initiator for the shared atomic port. It sits between a load-store unit's atomic request path and the central AMO unit (shared LR/SC reservation plus combinational AMO ALU). It sequences LR, SC and read-modify-write AMOs against a word-addressed memory port. One instance exists per agent, and one request is in flight at a time.

---
 rtl/riscv_types.sv | 26 ++
 rtl/amo_agent_sequencer_if.sv | 57 +++++
 rtl/amo_agent_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_types.sv
//------------------------------------------------------------------------------
// Module   : riscv_types (package)
// Brief    : Shared RISC-V type definitions used by the atomic path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_types;

    typedef enum logic [3:0] {
        AMO_LR   = 4'd0,
        AMO_SC   = 4'd1,
        AMO_SWAP = 4'd2,
        AMO_ADD  = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amo_t;

endpackage

`default_nettype wire

// File: rtl/amo_agent_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : amo_agent_sequencer_if
// Brief    : Request, response, memory and AMO-unit signals of one agent
//            sequencer; master = sequencer side, slave = surroundings.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface amo_agent_sequencer_if;
    import riscv_types::*;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    amo_t        req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        set_reservation;
    logic        clear_reservation;
    logic [31:0] reservation;
    logic        reservation_valid;
    logic        rmw_valid;
    amo_t        op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;

    modport master (
        input  req_valid, req_type, req_op, req_addr, req_data, rsp_ready,
               mem_req_ready, mem_rvalid, mem_rdata, reservation_valid, rd,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_req_valid, mem_we,
               mem_addr, mem_wdata, set_reservation, clear_reservation,
               reservation, rmw_valid, op, rs1, rs2
    );

    modport slave (
        output req_valid, req_type, req_op, req_addr, req_data, rsp_ready,
               mem_req_ready, mem_rvalid, mem_rdata, reservation_valid, rd,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_req_valid, mem_we,
               mem_addr, mem_wdata, set_reservation, clear_reservation,
               reservation, rmw_valid, op, rs1, rs2
    );

endinterface

`default_nettype wire

// File: rtl/amo_agent_sequencer.sv
//------------------------------------------------------------------------------
// Module   : amo_agent_sequencer
// Brief    : Per-agent LR/SC/AMO sequencer in front of the shared AMO unit.
//            Optional misalignment check: define AMO_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module amo_agent_sequencer
    import riscv_types::*;
#(
    parameter logic [31:0] SC_FAIL_VALUE              = 32'd1,
    parameter bit          WAIT_FOR_RVALID_EN_DEFAULT = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    amo_agent_sequencer_if.master  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_REQ   = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_ALU      = 3'd3;
    localparam logic [2:0] S_SC_CHECK = 3'd4;
    localparam logic [2:0] S_WR_REQ   = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        is_lr_q;
    logic        set_res_q;
    amo_t        op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rs1_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_data_q;
    logic        req_misaligned;
    logic        unused_cfg;

`ifdef AMO_ALIGN_CHECK_EN
    logic err_q;

    assign req_misaligned = (bus.req_addr[1:0] != 2'b00);
    assign bus.rsp_err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.req_valid) begin
            err_q <= req_misaligned;
        end
    end
`else
    assign req_misaligned = 1'b0;
    assign bus.rsp_err    = 1'b0;
`endif

    assign unused_cfg = ^{bus.req_addr[1:0], WAIT_FOR_RVALID_EN_DEFAULT};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (req_misaligned)             state_d = S_RESP;
                    else if (bus.req_type == 2'b01) state_d = S_SC_CHECK;
                    else                            state_d = S_RD_REQ;
                end
            end
            S_RD_REQ:   if (bus.mem_req_ready) state_d = S_RD_WAIT;
            S_RD_WAIT:  if (bus.mem_rvalid)    state_d = is_lr_q ? S_RESP : S_ALU;
            S_ALU:      state_d = S_WR_REQ;
            S_SC_CHECK: state_d = bus.reservation_valid ? S_WR_REQ : S_RESP;
            S_WR_REQ:   if (bus.mem_req_ready) state_d = S_RESP;
            S_RESP:     if (bus.rsp_ready)     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Reservation is killed by any SC attempt, and by an AMO that hits it.
    always_comb begin
        bus.req_ready         = (state_q == S_IDLE);
        bus.mem_req_valid     = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
        bus.mem_we            = (state_q == S_WR_REQ);
        bus.rmw_valid         = (state_q == S_ALU);
        bus.rsp_valid         = (state_q == S_RESP);
        bus.set_reservation   = set_res_q;
        bus.clear_reservation = (state_q == S_SC_CHECK) ||
                                ((state_q == S_ALU) && bus.reservation_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_lr_q    <= 1'b0;
            set_res_q  <= 1'b0;
            op_q       <= AMO_LR;
            addr_q     <= '0;
            data_q     <= '0;
            rs1_q      <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            set_res_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        is_lr_q    <= (bus.req_type == 2'b00);
                        op_q       <= bus.req_op;
                        addr_q     <= {bus.req_addr[31:2], 2'b00};
                        data_q     <= bus.req_data;
                        rsp_data_q <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.mem_rvalid) begin
                        rs1_q      <= bus.mem_rdata;
                        rsp_data_q <= bus.mem_rdata;
                        set_res_q  <= is_lr_q;
                    end
                end
                S_ALU: wdata_q <= bus.rd;
                S_SC_CHECK: begin
                    if (bus.reservation_valid) begin
                        wdata_q    <= data_q;
                        rsp_data_q <= '0;
                    end else begin
                        rsp_data_q <= SC_FAIL_VALUE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.reservation = addr_q;
    assign bus.op          = op_q;
    assign bus.rs1         = rs1_q;
    assign bus.rs2         = data_q;
    assign bus.rsp_data    = rsp_data_q;

endmodule

`default_nettype wire
